// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 9-bit XNOR generator (taps 9,5).
// Seeds from the line, verifies a run of predictions, then flywheels and tracks error density.
module lfsr_checker #(
    parameter int LOCK_LEN    = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int WINDOW      = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic             stuck,
    output logic [CNT_W-1:0] err_count
);

    localparam int MW = (LOCK_LEN > 1) ? $clog2(LOCK_LEN + 1) : 1;
    localparam int PW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS + 1) : 1;

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    state_t          state, state_nx;
    logic [8:0]      hist, hist_nx;
    logic [3:0]      fill, fill_nx;
    logic [MW-1:0]   match, match_nx;
    logic [PW-1:0]   win_pos, win_pos_nx;
    logic [EW-1:0]   win_err, win_err_nx;
    logic            err_pulse_nx, lock_lost_nx;
    logic [CNT_W-1:0] err_count_nx;
    logic            predicted, mismatch, counted_err;
    logic [8:0]      hist_rx;

    assign predicted = ~(hist[4] ^ hist[8]);
    assign mismatch  = bit_in != predicted;
    assign hist_rx   = {hist[7:0], bit_in};
    assign locked    = (state == LOCKED);
    assign stuck     = (hist == 9'h1FF);

    always_comb begin
        state_nx     = state;
        hist_nx      = hist;
        fill_nx      = fill;
        match_nx     = match;
        win_pos_nx   = win_pos;
        win_err_nx   = win_err;
        err_pulse_nx = 1'b0;
        lock_lost_nx = 1'b0;
        counted_err  = 1'b0;
        if (bit_valid) begin
            case (state)
                SEED: begin
                    hist_nx = hist_rx;
                    if (fill == 4'd8) begin
                        state_nx = VERIFY;
                        fill_nx  = '0;
                        match_nx = '0;
                    end else begin
                        fill_nx = fill + 4'd1;
                    end
                end
                VERIFY: begin
                    hist_nx = hist_rx;
                    // The all-ones lockup predicts itself forever, so never trust it.
                    if (mismatch || hist_rx == 9'h1FF) begin
                        state_nx = SEED;
                        fill_nx  = '0;
                    end else if (match == MW'(LOCK_LEN - 1)) begin
                        state_nx   = LOCKED;
                        match_nx   = '0;
                        win_pos_nx = '0;
                        win_err_nx = '0;
                    end else begin
                        match_nx = match + MW'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: the line bit is only compared, never loaded.
                    hist_nx      = {hist[7:0], predicted};
                    counted_err  = mismatch;
                    err_pulse_nx = mismatch;
                    if (mismatch && win_err == EW'(UNLOCK_ERRS - 1)) begin
                        state_nx     = SEED;
                        fill_nx      = '0;
                        lock_lost_nx = 1'b1;
                    end else if (win_pos == PW'(WINDOW - 1)) begin
                        win_pos_nx = '0;
                        win_err_nx = '0;
                    end else begin
                        win_pos_nx = win_pos + PW'(1);
                        win_err_nx = win_err + EW'(mismatch);
                    end
                end
                default: state_nx = SEED;
            endcase
        end
    end

    always_comb begin
        err_count_nx = err_count;
        if (err_clr)
            err_count_nx = counted_err ? CNT_W'(1) : '0;
        else if (counted_err && !(&err_count))
            err_count_nx = err_count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= SEED;
            hist      <= '0;
            fill      <= '0;
            match     <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            hist      <= hist_nx;
            fill      <= fill_nx;
            match     <= match_nx;
            win_pos   <= win_pos_nx;
            win_err   <= win_err_nx;
            err_pulse <= err_pulse_nx;
            lock_lost <= lock_lost_nx;
            err_count <= err_count_nx;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a queue-based behavioural model predicts the
// outputs after every clock, and a separate monitor compares them against the DUT.
module tb_lfsr_checker;

    localparam int LOCK_LEN    = 16;
    localparam int UNLOCK_ERRS = 4;
    localparam int WINDOW      = 32;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             err_clr = 1'b0;
    logic             locked, err_pulse, lock_lost, stuck;
    logic [CNT_W-1:0] err_count;

    lfsr_checker #(
        .LOCK_LEN(LOCK_LEN), .UNLOCK_ERRS(UNLOCK_ERRS), .WINDOW(WINDOW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .Reset(Reset), .bit_in(bit_in), .bit_valid(bit_valid), .err_clr(err_clr),
        .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost), .stuck(stuck),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             locked;
        logic             err_pulse;
        logic             lock_lost;
        logic             stuck;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: history as a bit queue (index 0 oldest, 8 newest).
    bit mh[$];
    int m_phase;   // 0 seeding, 1 verifying, 2 locked
    int m_fill, m_match, m_pos, m_werr, m_cnt;
    bit m_ep, m_ll;
    bit gq[$];     // generator history, same queue layout

    function automatic bit all_ones();
        foreach (mh[i]) if (!mh[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_push(input bit b);
        mh.push_back(b);
        mh.delete(0);
    endfunction

    function automatic bit gen_next();
        bit g;
        g = !(gq[4] ^ gq[0]);
        gq.push_back(g);
        gq.delete(0);
        return g;
    endfunction

    function automatic void model_step(input bit rst, input bit v, input bit b, input bit clr);
        bit p, err;
        err = 1'b0;
        if (rst) begin
            mh.delete();
            repeat (9) mh.push_back(1'b0);
            m_phase = 0; m_fill = 0; m_match = 0; m_pos = 0; m_werr = 0; m_cnt = 0;
            m_ep = 0; m_ll = 0;
            return;
        end
        m_ep = 0; m_ll = 0;
        if (v) begin
            p = !(mh[4] ^ mh[0]);
            if (m_phase == 0) begin
                m_push(b);
                m_fill++;
                if (m_fill == 9) begin m_phase = 1; m_match = 0; end
            end else if (m_phase == 1) begin
                m_push(b);
                if (b != p || all_ones()) begin
                    m_phase = 0; m_fill = 0;
                end else begin
                    m_match++;
                    if (m_match == LOCK_LEN) begin m_phase = 2; m_pos = 0; m_werr = 0; end
                end
            end else begin
                m_push(p);
                err = (b != p);
                m_ep = err;
                if (err) m_werr++;
                if (m_werr >= UNLOCK_ERRS) begin
                    m_phase = 0; m_fill = 0; m_ll = 1;
                end else begin
                    m_pos++;
                    if (m_pos == WINDOW) begin m_pos = 0; m_werr = 0; end
                end
            end
        end
        if (clr) m_cnt = err ? 1 : 0;
        else if (err && m_cnt < CNT_MAX) m_cnt++;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.locked    = (m_phase == 2);
        e.err_pulse = m_ep;
        e.lock_lost = m_ll;
        e.stuck     = all_ones();
        e.cnt       = CNT_W'(m_cnt);
        return e;
    endfunction

    task automatic cycle(input bit rst, input bit v, input bit b, input bit clr);
        @(negedge clk);
        Reset = rst; bit_valid = v; bit_in = b; err_clr = clr;
        @(posedge clk);
        #1;
        model_step(rst, v, b, clr);
        sbq.push_back(model_out());
    endtask

    task automatic run_clean(input int n);
        repeat (n) cycle(1'b0, 1'b1, gen_next(), 1'b0);
    endtask

    task automatic run_flip(input bit clr);
        cycle(1'b0, 1'b1, !gen_next(), clr);
    endtask

    // Monitor: compares every queued expectation after the edge it describes.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #2;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = {locked, err_pulse, lock_lost, stuck, err_count};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got locked=%b pulse=%b lost=%b stuck=%b cnt=%0d want locked=%b pulse=%b lost=%b stuck=%b cnt=%0d",
                             $time, a.locked, a.err_pulse, a.lock_lost, a.stuck, a.cnt,
                             e.locked, e.err_pulse, e.lock_lost, e.stuck, e.cnt);
                end
            end
        end
    end

    initial begin
        bit v;
        repeat (9) gq.push_back(1'b0);
        model_step(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset state, then lock from a zero-seeded generator and run a full period clean.
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_clean(25);
        run_clean(511);

        // Single flipped bit while locked.
        run_flip(1'b0);
        run_clean(60);

        // Fresh lock so the window starts at zero, then four errors in a row.
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_clean(25);
        repeat (4) run_flip(1'b0);
        run_clean(40);

        // Clear coinciding with an error, then clear alone.
        run_flip(1'b1);
        run_clean(3);
        cycle(1'b0, 1'b1, gen_next(), 1'b1);
        run_clean(3);

        // Drive err_count into saturation across repeated unlock/relock, then clear.
        repeat (5) begin
            repeat (4) run_flip(1'b0);
            run_clean(30);
        end
        cycle(1'b0, 1'b1, gen_next(), 1'b1);
        run_clean(5);

        // Asynchronous reset in the middle of a locked cycle.
        #2;
        Reset = 1'b1;
        #1;
        vectors++;
        if ({locked, err_pulse, lock_lost, stuck, err_count} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got locked=%b pulse=%b lost=%b stuck=%b cnt=%0d want all zero",
                     locked, err_pulse, lock_lost, stuck, err_count);
        end
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Constant ones: lockup pattern, never locks.
        repeat (20) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Clean stream with random gaps; garbage on invalid cycles must be ignored.
        repeat (300) begin
            v = ($urandom_range(0, 2) != 0);
            cycle(1'b0, v, v ? gen_next() : 1'($urandom_range(0, 1)), 1'b0);
        end

        // Random errors, gaps and clears.
        repeat (600) begin
            v = ($urandom_range(0, 3) != 0);
            if (v)
                cycle(1'b0, 1'b1, gen_next() ^ ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 19) == 0));
            else
                cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        repeat (3) @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_LEN, default 16: consecutive correct predictions required to declare lock.
REQ-002 Parameter UNLOCK_ERRS, default 4: mismatches within one window that force loss of lock.
REQ-003 Parameter WINDOW, default 32: length of the error-density window, in valid bits.
REQ-004 Parameter CNT_W, default 16: width of err_count.
REQ-005 Clock  input  1  single clock; all state changes on posedge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 bit_in  input  1  received serial bit, equal to the generator feedback bit of that step.
REQ-008 bit_valid  input  1  qualifies bit_in; when low, all state holds.
REQ-009 err_clr  input  1  synchronous clear of err_count.
REQ-010 locked  output  1  checker is synchronized to the sequence.
REQ-011 err_pulse  output  1  one-cycle flag, a mismatched bit was accepted while locked.
REQ-012 lock_lost  output  1  one-cycle flag, LOCKED exited due to error density.
REQ-013 stuck  output  1  history register holds the all-ones lockup pattern.
REQ-014 err_count  output  CNT_W  saturating count of mismatches while locked.

Function
REQ-015 Polynomial SHALL match the team's 9-bit generator: hist[8:0], hist[0] newest; predicted = hist[4] XNOR hist[8]; shift = {hist[7:0], new}.
REQ-016 States SHALL be SEED, VERIFY, LOCKED; nothing advances on a cycle where bit_valid=0.
REQ-017 SEED: shift bit_in into hist and count fills; after the 9th valid bit go to VERIFY with match count 0.
REQ-018 VERIFY: compare bit_in to predicted and shift bit_in in; match increments match count; mismatch returns to SEED with fill count 0.
REQ-019 VERIFY: if hist equals 9'h1FF after a shift, return to SEED (lockup is never accepted as lock).
REQ-020 VERIFY: the edge accepting the LOCK_LEN-th consecutive match SHALL enter LOCKED; locked=1 from the following cycle.
REQ-021 LOCKED: shift the predicted bit (not bit_in) into hist (flywheel), so a bad bit causes exactly one error.
REQ-022 LOCKED mismatch: err_pulse=1 for one cycle after the accepting edge; err_count += 1, saturating at all-ones.
REQ-023 LOCKED window: window position counts valid bits 0..WINDOW-1 and resets both itself and the window error count on wrap.
REQ-024 Window error count reaching UNLOCK_ERRS: go to SEED, locked=0 and lock_lost=1 for one cycle on the next cycle; err_count retained.
REQ-025 err_clr with a simultaneous counted error SHALL leave err_count=1; err_clr alone clears to 0; err_clr at saturation clears.
REQ-026 stuck SHALL be combinational on hist==9'h1FF in any state.
REQ-027 Mismatches in SEED/VERIFY SHALL NOT affect err_count or err_pulse.

Reset
REQ-028 Reset SHALL asynchronously set state SEED, hist=0, all counters=0, locked=0, err_pulse=0, lock_lost=0, err_count=0.
REQ-029 Reset asserted in LOCKED SHALL drop locked within the same cycle, without waiting for a clock edge.
REQ-030 After release, the first valid bit SHALL be treated as fill bit 1 of SEED.

Verification
REQ-031 Generator model seeded 0, bit_valid=1 every cycle -> locked=1 exactly after 25 valid bits (9+16); err_count=0 over 511 further bits.
REQ-032 While locked, flip one bit -> one err_pulse, err_count=1, locked stays 1, no further errors.
REQ-033 While locked, flip 4 bits within 32 -> lock_lost pulse, locked=0; clean stream relocks after 25 bits; err_count=4.
REQ-034 Constant bit_in=1 -> stuck=1 after 9 bits; locked never asserts.
REQ-035 Random bit_valid gaps on a clean stream -> lock after 25 valid bits; no errors; state frozen on invalid cycles.
REQ-036 err_clr with a simultaneous error -> err_count=1; Reset pulse mid-lock -> all outputs 0 immediately.
